// File: rtl/mux_bin_pipe.sv
// Pipelined binary-select multiplexer: a tree of SPLIT-way mux levels, each followed by a
// register stage, with valid/ready flow control that lets bubbles collapse.
module mux_bin_pipe #(
  parameter type          DAT_T     = logic [7:0],
  parameter int unsigned  WIDTH     = 16,
  parameter int unsigned  SPLIT     = 4,
  localparam int unsigned WIDTH_LOG = $clog2(WIDTH),
  localparam int unsigned SPLIT_LOG = $clog2(SPLIT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vld,
  output logic                 i_rdy,
  input  logic [WIDTH_LOG-1:0] bin,
  input  DAT_T [WIDTH-1:0]     ary,
  output logic                 o_vld,
  input  logic                 o_rdy,
  output DAT_T                 dat
);

  localparam int unsigned LEVELS = (WIDTH_LOG + SPLIT_LOG - 1) / SPLIT_LOG;
  localparam int unsigned BIN_W  = LEVELS * SPLIT_LOG;
  localparam int unsigned PAD    = 1 << BIN_W;

  logic [LEVELS-1:0] vld;
  logic [LEVELS-1:0] rdy;

  // A stage can load when it or any stage downstream of it is empty, or the sink is ready.
  for (genvar k = 0; k < LEVELS; k++) begin : g_rdy
    assign rdy[k] = o_rdy || !(&vld[LEVELS-1:k]);
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_stg
    localparam int unsigned NI = PAD >> (k * SPLIT_LOG);
    localparam int unsigned NO = NI >> SPLIT_LOG;
    localparam int unsigned SI = BIN_W - k * SPLIT_LOG;
    localparam int unsigned SO = SI - SPLIT_LOG;

    DAT_T [NI-1:0] a_in;
    DAT_T [NO-1:0] a_nxt;
    DAT_T [NO-1:0] a_q;
    logic [SI-1:0] s_in;
    logic          v_in;
    logic          vld_q;

    // Level 0 takes the zero-padded array; later levels take the previous register.
    if (k == 0) begin : g_head
      always_comb begin
        a_in            = '0;
        a_in[WIDTH-1:0] = ary;
      end
      assign s_in = SI'(bin);
      assign v_in = i_vld;
    end else begin : g_body
      assign a_in = g_stg[k-1].a_q;
      assign s_in = g_stg[k-1].g_sel.s_q;
      assign v_in = vld[k-1];
    end

    // Each group of SPLIT consecutive elements is reduced by the low select digit.
    for (genvar j = 0; j < NO; j++) begin : g_mux
      DAT_T [SPLIT-1:0] grp;
      assign grp      = a_in[j*SPLIT +: SPLIT];
      assign a_nxt[j] = grp[s_in[SPLIT_LOG-1:0]];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        a_q   <= '0;
      end else if (rdy[k]) begin
        vld_q <= v_in;
        if (v_in) begin
          a_q <= a_nxt;
        end
      end
    end

    // Remaining select digits travel with the data; the final level has none left.
    if (SO > 0) begin : g_sel
      logic [SO-1:0] s_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          s_q <= '0;
        end else if (rdy[k] && v_in) begin
          s_q <= s_in[SI-1:SPLIT_LOG];
        end
      end
    end

    assign vld[k] = vld_q;
  end

  assign i_rdy = rdy[0] && !rst;
  assign o_vld = vld[LEVELS-1];
  assign dat   = g_stg[LEVELS-1].a_q[0];

endmodule
